sudoku_input_ctrl: RTL and testbench



---
 rtl/sudoku_input_ctrl_if.sv | 45 ++++
 rtl/sudoku_input_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_sudoku_input_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/sudoku_input_ctrl_if.sv
// -----------------------------------------------------------------------------
// sudoku_input_ctrl_if
// Purpose : bundles the raw board controls and the conditioned command outputs
//           exchanged between the board side and sudoku_input_ctrl.
// Signals :
//   btn_up/down/left/right  raw direction buttons, active-high, asynchronous
//   btn_enter/clear/new     raw action buttons, active-high, asynchronous
//   sw_num[3:0]             raw number switches, asynchronous
//   row_sel[3:0]            bit0 up pulse, bit1 down pulse, bits3:2 zero
//   col_sel[3:0]            bit0 left pulse, bit1 right pulse, bits3:2 zero
//   num_in[3:0]             switch value captured with the last enter pulse
//   enter/clear/new_game    single-cycle command pulses
// Modports:
//   master : board / stimulus side (drives raw inputs, observes commands)
//   slave  : sudoku_input_ctrl side (reads raw inputs, drives commands)
// -----------------------------------------------------------------------------
interface sudoku_input_ctrl_if;
   logic       btn_up;
   logic       btn_down;
   logic       btn_left;
   logic       btn_right;
   logic       btn_enter;
   logic       btn_clear;
   logic       btn_new;
   logic [3:0] sw_num;

   logic [3:0] row_sel;
   logic [3:0] col_sel;
   logic [3:0] num_in;
   logic       enter;
   logic       clear;
   logic       new_game;

   modport master (
      output btn_up, btn_down, btn_left, btn_right,
      output btn_enter, btn_clear, btn_new, sw_num,
      input  row_sel, col_sel, num_in, enter, clear, new_game
   );

   modport slave (
      input  btn_up, btn_down, btn_left, btn_right,
      input  btn_enter, btn_clear, btn_new, sw_num,
      output row_sel, col_sel, num_in, enter, clear, new_game
   );
endinterface

// File: rtl/sudoku_input_ctrl.sv
// -----------------------------------------------------------------------------
// sudoku_input_ctrl
// Purpose : front-end conditioner between board buttons/switches and the sudoku
//           game core. Every raw input is double-flop synchronised, each button
//           is debounced and rise-detected, and registered one-cycle command
//           pulses are produced. new_game only fires after a long press.
// Ports   :
//   clk     in  system clock
//   reset   in  asynchronous, active-high reset (clears every flop)
//   bus     sudoku_input_ctrl_if.slave (raw inputs in, command pulses out)
// Parameters:
//   DEBOUNCE_CNT  stable cycles needed to accept a level change (>= 2)
//   NEWGAME_HOLD  debounced-high cycles of btn_new before new_game (>= 1)
//   REPEAT_DELAY  cycles from a direction pulse to its first auto-repeat
//   REPEAT_RATE   cycles between later auto-repeats
// Optional feature:
//   KEY_REPEAT_EN  when defined, held direction buttons auto-repeat. When not
//                  defined, each press yields exactly one pulse and the repeat
//                  logic is absent.
// Latency : a press first sampled at edge N pulses in the cycle after edge
//           N+DEBOUNCE_CNT+3; new_game follows NEWGAME_HOLD cycles after the
//           edge at which btn_new's debounced level rises.
// -----------------------------------------------------------------------------
module sudoku_input_ctrl #(
   parameter logic [15:0] DEBOUNCE_CNT = 16'd50000,
   parameter logic [23:0] NEWGAME_HOLD = 24'd5000000,
   parameter logic [23:0] REPEAT_DELAY = 24'd10000000,
   parameter logic [23:0] REPEAT_RATE  = 24'd2500000
) (
   input  logic                clk,
   input  logic                reset,
   sudoku_input_ctrl_if.slave  bus
);

   // Button index map used by the per-button vectors below.
   localparam int NBTN    = 7;
   localparam int B_UP    = 0;
   localparam int B_DOWN  = 1;
   localparam int B_LEFT  = 2;
   localparam int B_RIGHT = 3;
   localparam int B_ENTER = 4;
   localparam int B_CLEAR = 5;
   localparam int B_NEW   = 6;

   // Debounce counter just wide enough to hold DEBOUNCE_CNT itself.
   localparam int                DEB_W   = $clog2(int'(DEBOUNCE_CNT) + 1);
   localparam logic [DEB_W-1:0]  DEB_MAX = DEB_W'(DEBOUNCE_CNT);

   // Hold counter only needs to reach NEWGAME_HOLD-1.
   localparam int                HOLD_W    = (NEWGAME_HOLD > 24'd1) ? $clog2(int'(NEWGAME_HOLD)) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(NEWGAME_HOLD - 24'd1);

   // Elaboration-time guards on parameter ranges.
   generate
      if (DEBOUNCE_CNT < 16'd2) begin : g_bad_debounce
         $error("sudoku_input_ctrl: DEBOUNCE_CNT must be at least 2");
      end
      if (NEWGAME_HOLD < 24'd1) begin : g_bad_hold
         $error("sudoku_input_ctrl: NEWGAME_HOLD must be at least 1");
      end
      if ((REPEAT_DELAY < 24'd1) || (REPEAT_RATE < 24'd1)) begin : g_bad_repeat
         $error("sudoku_input_ctrl: REPEAT_DELAY and REPEAT_RATE must be at least 1");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Raw inputs gathered into one vector so sync/debounce is generated.
   // ------------------------------------------------------------------
   logic [NBTN-1:0] w_raw;
   logic [NBTN-1:0] w_stable;       // current debounced level
   logic [NBTN-1:0] w_stable_next;  // debounced level after the coming edge

   assign w_raw = {bus.btn_new, bus.btn_clear, bus.btn_enter,
                   bus.btn_right, bus.btn_left, bus.btn_down, bus.btn_up};

   generate
      for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
         logic             r_sync1;
         logic             r_sync2;
         logic             r_stable;
         logic [DEB_W-1:0] r_cnt;
         logic             w_differ;
         logic             w_accept;

         assign w_differ          = (r_sync2 != r_stable);
         // The counter must sit at DEBOUNCE_CNT for one cycle with the
         // levels still differing before the new level is taken.
         assign w_accept          = w_differ && (r_cnt == DEB_MAX);
         assign w_stable_next[gi] = w_accept ? r_sync2 : r_stable;
         assign w_stable[gi]      = r_stable;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_sync1  <= 1'b0;
               r_sync2  <= 1'b0;
               r_stable <= 1'b0;
               r_cnt    <= '0;
            end else begin
               r_sync1  <= w_raw[gi];
               r_sync2  <= r_sync1;
               r_stable <= w_stable_next[gi];
               if (!w_differ || w_accept) begin
                  r_cnt <= '0;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
         end
      end
   endgenerate

   // Switch synchroniser, per bit; no debounce, value is sampled at enter.
   logic [3:0] r_sw_sync1;
   logic [3:0] r_sw_sync2;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sw_sync1 <= 4'd0;
         r_sw_sync2 <= 4'd0;
      end else begin
         r_sw_sync1 <= bus.sw_num;
         r_sw_sync2 <= r_sw_sync1;
      end
   end

   // ------------------------------------------------------------------
   // Press events: 0->1 of the debounced level, for the six buttons that
   // produce direct pulses. btn_new is handled by the long-press FSM.
   // ------------------------------------------------------------------
   logic [5:0] r_stable_d;
   logic [5:0] w_rise;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_stable_d <= 6'd0;
      end else begin
         r_stable_d <= w_stable[5:0];
      end
   end

   assign w_rise = w_stable[5:0] & ~r_stable_d;

   // ------------------------------------------------------------------
   // Direction auto-repeat
   // ------------------------------------------------------------------
   logic [3:0] w_rep;

`ifdef KEY_REPEAT_EN
   localparam int               REP_W = ((REPEAT_DELAY > REPEAT_RATE) ?
                                         (REPEAT_DELAY > 24'd1 ? $clog2(int'(REPEAT_DELAY)) : 1) :
                                         (REPEAT_RATE  > 24'd1 ? $clog2(int'(REPEAT_RATE))  : 1));
   localparam logic [REP_W-1:0] REP_DELAY_LAST = REP_W'(REPEAT_DELAY - 24'd1);
   localparam logic [REP_W-1:0] REP_RATE_LAST  = REP_W'(REPEAT_RATE - 24'd1);

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_rep
         logic [REP_W-1:0] r_rep_cnt;
         logic             r_rep_phase;   // 0: waiting initial delay, 1: steady rate
         logic             w_hit;

         assign w_hit = w_stable[gi] && !w_rise[gi] &&
                        (r_rep_phase ? (r_rep_cnt == REP_RATE_LAST)
                                     : (r_rep_cnt == REP_DELAY_LAST));
         assign w_rep[gi] = w_hit;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_rep_cnt   <= '0;
               r_rep_phase <= 1'b0;
            end else if (w_rise[gi] || !w_stable[gi]) begin
               // Fresh press restarts the delay; release parks the counter.
               r_rep_cnt   <= '0;
               r_rep_phase <= 1'b0;
            end else if (w_hit) begin
               r_rep_cnt   <= '0;
               r_rep_phase <= 1'b1;
            end else begin
               r_rep_cnt   <= r_rep_cnt + 1'b1;
            end
         end
      end
   endgenerate
`else
   assign w_rep = 4'b0000;
`endif

   // ------------------------------------------------------------------
   // new_game long-press FSM
   // ------------------------------------------------------------------
   typedef enum logic [1:0] {
      NG_IDLE  = 2'd0,
      NG_HOLD  = 2'd1,
      NG_FIRED = 2'd2
   } ng_state_t;

   ng_state_t         r_ng_state;
   ng_state_t         w_ng_state_next;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_hold_cnt_next;
   logic              w_ng_fire;
   logic              w_new_rise;
   logic              w_new_fall;

   // Strobes for the edge at which btn_new's debounced level changes, so the
   // FSM moves in step with the debounced level itself.
   assign w_new_rise = w_stable_next[B_NEW] & ~w_stable[B_NEW];
   assign w_new_fall = ~w_stable_next[B_NEW] & w_stable[B_NEW];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_ng_state <= NG_IDLE;
         r_hold_cnt <= '0;
      end else begin
         r_ng_state <= w_ng_state_next;
         r_hold_cnt <= w_hold_cnt_next;
      end
   end

   always_comb begin
      w_ng_state_next = r_ng_state;
      w_hold_cnt_next = r_hold_cnt;
      w_ng_fire       = 1'b0;
      case (r_ng_state)
         NG_IDLE: begin
            if (w_new_rise) begin
               w_ng_state_next = NG_HOLD;
               w_hold_cnt_next = '0;
            end
         end
         NG_HOLD: begin
            if (w_new_fall) begin
               w_ng_state_next = NG_IDLE;
               w_hold_cnt_next = '0;
            end else if (r_hold_cnt == HOLD_LAST) begin
               w_ng_state_next = NG_FIRED;
               w_ng_fire       = 1'b1;
            end else begin
               w_hold_cnt_next = r_hold_cnt + 1'b1;
            end
         end
         NG_FIRED: begin
            if (w_new_fall) begin
               w_ng_state_next = NG_IDLE;
               w_hold_cnt_next = '0;
            end
         end
         default: begin
            w_ng_state_next = NG_IDLE;
            w_hold_cnt_next = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Command arbitration and registered outputs
   // ------------------------------------------------------------------
   logic [3:0] w_dir_ev;
   logic [1:0] w_row_next;
   logic [1:0] w_col_next;
   logic       w_enter_ev;
   logic       w_clear_ev;

   assign w_dir_ev = w_rise[3:0] | w_rep;

   // Opposing directions cancel; new_game wipes out any direction that cycle.
   assign w_row_next = ((w_dir_ev[B_UP] ^ w_dir_ev[B_DOWN]) && !w_ng_fire) ?
                       w_dir_ev[B_DOWN:B_UP] : 2'b00;
   assign w_col_next = ((w_dir_ev[B_LEFT] ^ w_dir_ev[B_RIGHT]) && !w_ng_fire) ?
                       w_dir_ev[B_RIGHT:B_LEFT] : 2'b00;

   // new_game > enter > clear; losers are dropped, not deferred.
   assign w_enter_ev = w_rise[B_ENTER] & ~w_ng_fire;
   assign w_clear_ev = w_rise[B_CLEAR] & ~w_rise[B_ENTER] & ~w_ng_fire;

   logic [1:0] r_row_sel;
   logic [1:0] r_col_sel;
   logic [3:0] r_num_in;
   logic       r_enter;
   logic       r_clear;
   logic       r_new_game;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_row_sel  <= 2'b00;
         r_col_sel  <= 2'b00;
         r_num_in   <= 4'd0;
         r_enter    <= 1'b0;
         r_clear    <= 1'b0;
         r_new_game <= 1'b0;
      end else begin
         r_row_sel  <= w_row_next;
         r_col_sel  <= w_col_next;
         r_enter    <= w_enter_ev;
         r_clear    <= w_clear_ev;
         r_new_game <= w_ng_fire;
         // Captured on the same edge that raises enter so both line up.
         if (w_enter_ev) begin
            r_num_in <= r_sw_sync2;
         end
      end
   end

   assign bus.row_sel  = {2'b00, r_row_sel};
   assign bus.col_sel  = {2'b00, r_col_sel};
   assign bus.num_in   = r_num_in;
   assign bus.enter    = r_enter;
   assign bus.clear    = r_clear;
   assign bus.new_game = r_new_game;

endmodule

// File: tb/tb_sudoku_input_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sudoku_input_ctrl
// Directed stimulus with a cycle-stamped expectation queue. The stimulus process
// pushes the expected output pattern for a given cycle; a monitor on the falling
// edge pops and compares when that cycle arrives, and flags any pulse that has
// no matching expectation. Parameters: DEBOUNCE_CNT=4, NEWGAME_HOLD=8,
// REPEAT_DELAY=10, REPEAT_RATE=3.
// Timing used for the hand-computed cycles (E = cycle count when an input is
// driven, just after edge E):
//   first sample edge N = E+1, sync adds 1, debounce accepts at N+6,
//   press pulse visible in cycle N+7 = E+8,
//   new_game visible NEWGAME_HOLD cycles after the debounced rise: E+7+8 = E+15.
// -----------------------------------------------------------------------------
module tb_sudoku_input_ctrl;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   always #5 clk = ~clk;

   sudoku_input_ctrl_if bus();

   sudoku_input_ctrl #(
      .DEBOUNCE_CNT (16'd4),
      .NEWGAME_HOLD (24'd8),
      .REPEAT_DELAY (24'd10),
      .REPEAT_RATE  (24'd3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      int unsigned cyc;
      logic [3:0]  row;
      logic [3:0]  col;
      logic        ent;
      logic        clr;
      logic        ng;
      logic [3:0]  num;
   } exp_t;

   exp_t        exp_q[$];
   int unsigned cyc    = 0;
   int          n_vec  = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk) begin
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         n_vec++;
         n_fail++;
         $display("FAIL %s: expectation for cycle %0d was never checked", e.name, e.cyc);
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         n_vec++;
         if ({bus.row_sel, bus.col_sel, bus.enter, bus.clear, bus.new_game, bus.num_in} !==
             {e.row, e.col, e.ent, e.clr, e.ng, e.num}) begin
            n_fail++;
            $display("FAIL %s cyc=%0d: got row=%b col=%b ent=%b clr=%b ng=%b num=%0d, want row=%b col=%b ent=%b clr=%b ng=%b num=%0d",
                     e.name, cyc, bus.row_sel, bus.col_sel, bus.enter, bus.clear, bus.new_game, bus.num_in,
                     e.row, e.col, e.ent, e.clr, e.ng, e.num);
         end else begin
            $display("ok   %s cyc=%0d row=%b col=%b ent=%b clr=%b ng=%b num=%0d",
                     e.name, cyc, bus.row_sel, bus.col_sel, bus.enter, bus.clear, bus.new_game, bus.num_in);
         end
      end else if (bus.row_sel != 4'd0 || bus.col_sel != 4'd0 ||
                   bus.enter || bus.clear || bus.new_game) begin
         n_vec++;
         n_fail++;
         $display("FAIL unexpected_pulse cyc=%0d: got row=%b col=%b ent=%b clr=%b ng=%b, want all zero",
                  cyc, bus.row_sel, bus.col_sel, bus.enter, bus.clear, bus.new_game);
      end
   end

   // ---------------- helpers ----------------
   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_at(input string nm, input int unsigned c,
                            input logic [3:0] row, input logic [3:0] col,
                            input logic ent, input logic clr, input logic ng,
                            input logic [3:0] num);
      exp_t e;
      int   i;
      e.name = nm; e.cyc = c; e.row = row; e.col = col;
      e.ent = ent; e.clr = clr; e.ng = ng; e.num = num;
      i = 0;
      while (i < exp_q.size() && exp_q[i].cyc <= c) i++;
      exp_q.insert(i, e);
   endtask

   // Direction press driven at cycle e, debounced level high for 'held' cycles.
   task automatic expect_dir(input string nm, input int unsigned e, input int held,
                             input logic [3:0] row, input logic [3:0] col,
                             input logic [3:0] num);
      expect_at(nm, e + 8, row, col, 1'b0, 1'b0, 1'b0, num);
`ifdef KEY_REPEAT_EN
      for (int k = 10; k < held; k += 3) begin
         expect_at({nm, "_rep"}, e + 8 + k, row, col, 1'b0, 1'b0, 1'b0, num);
      end
`else
      if (held < 0) $display("note: negative hold for %s", nm);
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int unsigned e;
      bus.btn_up = 0; bus.btn_down = 0; bus.btn_left = 0; bus.btn_right = 0;
      bus.btn_enter = 0; bus.btn_clear = 0; bus.btn_new = 0; bus.sw_num = 4'd0;

      // Reset state and idle
      expect_at("reset_state_c1", 1, 4'd0, 4'd0, 0, 0, 0, 4'd0);
      expect_at("reset_state_c2", 2, 4'd0, 4'd0, 0, 0, 0, 4'd0);
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      expect_at("first_edge_after_reset", cyc + 1, 4'd0, 4'd0, 0, 0, 0, 4'd0);
      expect_at("idle_10", cyc + 10, 4'd0, 4'd0, 0, 0, 0, 4'd0);
      expect_at("idle_20", cyc + 20, 4'd0, 4'd0, 0, 0, 0, 4'd0);
      tick(22);

      // Clean down press, 20 cycles, single pulse, none on release
      e = cyc; bus.btn_down = 1;
      expect_dir("down_press", e, 20, 4'b0010, 4'b0000, 4'd0);
      tick(20); bus.btn_down = 0; tick(20);

      // 3-cycle glitch on right must be rejected
      e = cyc; bus.btn_right = 1;
      expect_at("right_glitch", e + 8, 4'd0, 4'd0, 0, 0, 0, 4'd0);
      tick(3); bus.btn_right = 0; tick(15);

      // enter captures sw_num=3; later switch change does not disturb num_in
      bus.sw_num = 4'd3; tick(4);
      e = cyc; bus.btn_enter = 1;
      expect_at("enter_num3", e + 8, 4'd0, 4'd0, 1, 0, 0, 4'd3);
      tick(10); bus.btn_enter = 0; bus.sw_num = 4'd1; tick(15);
      expect_at("num_hold3", cyc + 1, 4'd0, 4'd0, 0, 0, 0, 4'd3);
      tick(5);

      // up and down together cancel
      e = cyc; bus.btn_up = 1; bus.btn_down = 1;
      expect_at("updown_conflict", e + 8, 4'd0, 4'd0, 0, 0, 0, 4'd3);
      tick(15); bus.btn_up = 0; bus.btn_down = 0; tick(15);

      // row and column pulses may coincide
      e = cyc; bus.btn_up = 1; bus.btn_right = 1;
      expect_dir("up_right_same", e, 15, 4'b0001, 4'b0010, 4'd3);
      tick(15); bus.btn_up = 0; bus.btn_right = 0; tick(15);

      // enter beats clear; num_in takes the current switches (1)
      e = cyc; bus.btn_enter = 1; bus.btn_clear = 1;
      expect_at("enter_over_clear", e + 8, 4'd0, 4'd0, 1, 0, 0, 4'd1);
      tick(12); bus.btn_enter = 0; bus.btn_clear = 0; tick(15);

      // short tap of new: 5 stable cycles, no new_game
      e = cyc; bus.btn_new = 1;
      expect_at("new_short_tap", e + 15, 4'd0, 4'd0, 0, 0, 0, 4'd1);
      tick(5); bus.btn_new = 0; tick(20);

      // long hold: one new_game; an up press landing in that cycle is suppressed
      e = cyc; bus.btn_new = 1;
      expect_at("new_long_hold", e + 15, 4'd0, 4'd0, 0, 0, 1, 4'd1);
      tick(7); bus.btn_up = 1; tick(6); bus.btn_up = 0;
      tick(17); bus.btn_new = 0; tick(20);

      // reset in mid-hold: no pulse; held button must re-debounce afterwards
      e = cyc; bus.btn_new = 1;
      tick(10);
      reset = 1'b1;
      expect_at("reset_mid_hold", cyc + 1, 4'd0, 4'd0, 0, 0, 0, 4'd0);
      tick(2);
      reset = 1'b0;
      e = cyc;
      expect_at("new_after_reset", e + 15, 4'd0, 4'd0, 0, 0, 1, 4'd0);
      tick(25); bus.btn_new = 0; tick(20);

      // left held 25 stable cycles (repeats only with the optional feature)
      e = cyc; bus.btn_left = 1;
      expect_dir("left_hold", e, 25, 4'b0000, 4'b0001, 4'd0);
      tick(25); bus.btn_left = 0; tick(30);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
